// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor:
//   - state_t     : 3-bit supervisor state, encodings also driven on STATE
//   - STATE_*     : raw encodings of the STATE port
//   - ctrl_t      : registered control outputs decoded from a state
//   - state_outputs() : state -> control output decode
//   - max3()      : helper for sizing the shared cycle timer
// Optional feature macro used by the block: PLL_SUP_LOSS_COUNTER_EN.
package pll_sup_pkg;

  localparam logic [2:0] STATE_PWRDN     = 3'd0;
  localparam logic [2:0] STATE_WAIT_LOCK = 3'd1;
  localparam logic [2:0] STATE_STABLE    = 3'd2;
  localparam logic [2:0] STATE_RUN       = 3'd3;
  localparam logic [2:0] STATE_FAULT     = 3'd4;

  typedef enum logic [2:0] {
    ST_PWRDN     = STATE_PWRDN,
    ST_WAIT_LOCK = STATE_WAIT_LOCK,
    ST_STABLE    = STATE_STABLE,
    ST_RUN       = STATE_RUN,
    ST_FAULT     = STATE_FAULT
  } state_t;

  typedef struct packed {
    logic pll_powerdown_n;
    logic sys_reset;
    logic ready;
    logic fault;
  } ctrl_t;

  // Outputs are a pure function of the state being entered, so the FSM
  // loads them together with the state register and they stay registered.
  function automatic ctrl_t state_outputs(input state_t s);
    ctrl_t c;
    c.pll_powerdown_n = 1'b0;
    c.sys_reset       = 1'b1;
    c.ready           = 1'b0;
    c.fault           = 1'b0;
    case (s)
      ST_WAIT_LOCK, ST_STABLE: c.pll_powerdown_n = 1'b1;
      ST_RUN: begin
        c.pll_powerdown_n = 1'b1;
        c.sys_reset       = 1'b0;
        c.ready           = 1'b1;
      end
      ST_FAULT: c.fault = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if
// Groups the supervisor's PLL-facing and status signals.
//   master : environment side (drives PLL_LOCK, RESTART)
//   slave  : supervisor side (drives power-down, reset and status outputs)
// With PLL_SUP_LOSS_COUNTER_EN defined, LOSS_COUNT[7:0] is added.
interface pll_lock_supervisor_if;
  logic       PLL_LOCK;
  logic       RESTART;
  logic       PLL_POWERDOWN_N;
  logic       SYS_RESET;
  logic       READY;
  logic       FAULT;
  logic [2:0] STATE;
  logic [1:0] RETRY_COUNT;
`ifdef PLL_SUP_LOSS_COUNTER_EN
  logic [7:0] LOSS_COUNT;

  modport master (
    output PLL_LOCK, RESTART,
    input  PLL_POWERDOWN_N, SYS_RESET, READY, FAULT, STATE, RETRY_COUNT, LOSS_COUNT
  );
  modport slave (
    input  PLL_LOCK, RESTART,
    output PLL_POWERDOWN_N, SYS_RESET, READY, FAULT, STATE, RETRY_COUNT, LOSS_COUNT
  );
`else
  modport master (
    output PLL_LOCK, RESTART,
    input  PLL_POWERDOWN_N, SYS_RESET, READY, FAULT, STATE, RETRY_COUNT
  );
  modport slave (
    input  PLL_LOCK, RESTART,
    output PLL_POWERDOWN_N, SYS_RESET, READY, FAULT, STATE, RETRY_COUNT
  );
`endif
endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// sync_2ff
// Generic two-flop synchronizer for a single asynchronous status bit.
//   clk : destination clock
//   rst : asynchronous active-high reset, flops clear to 0
//   i_d : asynchronous input
//   o_q : synchronized output, two destination edges of latency
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Sequences a PLL through power-down, lock wait, lock qualification and run,
// retrying on lock timeout and latching a fault after repeated failures.
// Produces a clean reset for the PLL clock domain.
//   CLK : free-running reference clock (also the PLL reference)
//   RST : asynchronous active-high reset
//   bus : pll_lock_supervisor_if.slave
//         in : PLL_LOCK (async), RESTART (single-cycle)
//         out: PLL_POWERDOWN_N, SYS_RESET, READY, FAULT, STATE[2:0],
//              RETRY_COUNT[1:0], LOSS_COUNT[7:0] (PLL_SUP_LOSS_COUNTER_EN only)
// Optional macro: PLL_SUP_LOSS_COUNTER_EN adds a saturating lock-loss counter.
module pll_lock_supervisor #(
  parameter int PD_CYCLES          = 16,
  parameter int LOCK_TIMEOUT       = 4096,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int MAX_RETRIES        = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  pll_lock_supervisor_if.slave bus
);

  import pll_sup_pkg::*;

  // One timer serves every timed phase: only one phase is active at a time
  // and the timer is cleared on each state entry.
  localparam int CNT_MAX = max3(PD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] PD_LAST     = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_LAST  = 2'(MAX_RETRIES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_retry;
  ctrl_t            r_ctrl;
  logic             w_lock_s;

  sync_2ff u_lock_sync (
    .clk (CLK),
    .rst (RST),
    .i_d (bus.PLL_LOCK),
    .o_q (w_lock_s)
  );

  // RESTART overrides every other transition. A retry is charged only when a
  // lock window times out; a lock drop during qualification is not a retry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_PWRDN;
      r_cnt   <= '0;
      r_retry <= '0;
      r_ctrl  <= state_outputs(ST_PWRDN);
    end else if (bus.RESTART) begin
      r_state <= ST_PWRDN;
      r_cnt   <= '0;
      r_retry <= '0;
      r_ctrl  <= state_outputs(ST_PWRDN);
    end else begin
      case (r_state)
        ST_PWRDN: begin
          if (r_cnt == PD_LAST) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
            r_ctrl  <= state_outputs(ST_WAIT_LOCK);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_ctrl  <= state_outputs(ST_STABLE);
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_cnt <= '0;
            if (r_retry == RETRY_LAST) begin
              r_state <= ST_FAULT;
              r_ctrl  <= state_outputs(ST_FAULT);
            end else begin
              r_retry <= r_retry + 2'd1;
              r_state <= ST_PWRDN;
              r_ctrl  <= state_outputs(ST_PWRDN);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!w_lock_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
            r_ctrl  <= state_outputs(ST_WAIT_LOCK);
          end else if (r_cnt == STABLE_LAST) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_retry <= '0;
            r_ctrl  <= state_outputs(ST_RUN);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
            r_ctrl  <= state_outputs(ST_WAIT_LOCK);
          end
        end
        ST_FAULT: ;
        default: begin
          r_state <= ST_PWRDN;
          r_cnt   <= '0;
          r_ctrl  <= state_outputs(ST_PWRDN);
        end
      endcase
    end
  end

  assign bus.PLL_POWERDOWN_N = r_ctrl.pll_powerdown_n;
  assign bus.SYS_RESET       = r_ctrl.sys_reset;
  assign bus.READY           = r_ctrl.ready;
  assign bus.FAULT           = r_ctrl.fault;
  assign bus.STATE           = r_state;
  assign bus.RETRY_COUNT     = r_retry;

`ifdef PLL_SUP_LOSS_COUNTER_EN
  logic [7:0] r_loss_count;

  // Counts RUN -> WAIT_LOCK lock losses; a RESTART in the same cycle wins,
  // so that case is not a loss event. Only RST clears the count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_loss_count <= '0;
    end else if (!bus.RESTART && (r_state == ST_RUN) && !w_lock_s &&
                 (r_loss_count != 8'hFF)) begin
      r_loss_count <= r_loss_count + 8'd1;
    end
  end

  assign bus.LOSS_COUNT = r_loss_count;
`endif

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Controls the power-down input of a fabric CCC/PLL wrapper and monitors its asynchronous lock output.
- Produces a clean, debounced reset for the PLL-clocked downstream logic.
- Runs on the free-running reference clock that also feeds the PLL.
- Sequence: power-up, lock-timeout retries, lock-loss recovery, and a latched fault after repeated failure.

Parameters:
PD_CYCLES, 16, cycles PLL_POWERDOWN_N held low per power-down phase (>=2)
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before a retry
LOCK_STABLE_CYCLES, 256, consecutive synchronized-lock cycles required before release
MAX_RETRIES, 3, failed lock attempts allowed before FAULT

Ports:
CLK  in  1  reference clock, same source as the PLL REF_CLK
RST  in  1  asynchronous, active-high reset
PLL_LOCK  in  1  PLL lock, asynchronous to CLK
RESTART  in  1  single-cycle request to restart the sequence
PLL_POWERDOWN_N  out  1  to PLL power-down input, active-low
SYS_RESET  out  1  active-high reset for PLL-clock-domain logic
READY  out  1  PLL locked and stable
FAULT  out  1  retries exhausted
STATE  out  3  current state encoding
RETRY_COUNT  out  2  failed attempts since last RUN/RESTART

Behaviour:
- Interface: one clock, CLK; reset RST is asynchronous and active-high.
- PLL_LOCK passes through a 2-flop synchronizer (lock_s). No other CDC.
- States: PWRDN=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4. All outputs are registered and decoded from the state register.
- RST values: state PWRDN, PLL_POWERDOWN_N=0, SYS_RESET=1, READY=0, FAULT=0, all counters 0.
- PWRDN:
  - PLL_POWERDOWN_N=0, SYS_RESET=1.
  - After PD_CYCLES cycles, go to WAIT_LOCK; the timer clears.
- WAIT_LOCK:
  - PLL_POWERDOWN_N=1, SYS_RESET=1, timer increments.
  - lock_s=1: go to STABLE, stable counter cleared.
  - Timer reaches LOCK_TIMEOUT-1 with lock_s=0 and RETRY_COUNT==MAX_RETRIES-1: go to FAULT.
  - Otherwise on timeout: RETRY_COUNT++, go to PWRDN.
- STABLE:
  - Stable counter increments while lock_s=1.
  - lock_s=0: return to WAIT_LOCK, timer cleared, no retry charged.
  - Counter reaches LOCK_STABLE_CYCLES-1: go to RUN, RETRY_COUNT cleared.
- RUN:
  - SYS_RESET=0, READY=1.
  - lock_s=0: go to WAIT_LOCK. SYS_RESET=1 and READY=0 from that edge.
- FAULT:
  - PLL_POWERDOWN_N=0, SYS_RESET=1, FAULT=1.
  - Holds until RESTART or RST.
- RESTART=1 in any state, including FAULT: go to PWRDN, counters and RETRY_COUNT cleared. RESTART has priority over all other transitions in the same cycle.
- Latency:
  - PLL_LOCK rise to READY rise: 2 (sync) + 1 + LOCK_STABLE_CYCLES edges, if lock holds.
  - PLL_LOCK fall in RUN to SYS_RESET=1: <=3 edges.
- Counter widths are derived with $clog2 of the max count, never wrapping; each counter is cleared on state entry.
- RST mid-operation: immediate return to reset values. PLL_POWERDOWN_N drops asynchronously.

Optional Feature:
- Macro: PLL_SUP_LOSS_COUNTER_EN.
- Defined:
  - Adds an output LOSS_COUNT [7:0]: count of RUN->WAIT_LOCK lock-loss events.
  - Saturates at 255, clears only on RST.
  - RESTART does not clear it.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package pll_sup_pkg holds:
  - state enum typedef (3-bit, encodings above);
  - encoding constants used for the STATE port.
- One natural sub-module: sync_2ff (generic 2-flop bit synchronizer, async active-high reset to 0), reusable for other async status inputs.

Test Plan (PD_CYCLES=4, LOCK_TIMEOUT=16, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2):
- Nominal lock: release RST, PLL_LOCK rises 5 cycles after PLL_POWERDOWN_N rises, held -> STATE 0->1->2->3, READY=1 and SYS_RESET=0 exactly 11 edges after PLL_LOCK rise.
- Timeout/retry/fault: PLL_LOCK held 0 -> two 16-cycle WAIT_LOCK windows, each with RETRY_COUNT/PD logic as specified; STATE=4, FAULT=1, PLL_POWERDOWN_N=0 after the second timeout.
- Lock glitch in STABLE: PLL_LOCK low 3 cycles after 4 stable cycles -> return to WAIT_LOCK, RETRY_COUNT unchanged, READY stays 0 until 8 new consecutive locked cycles.
- Lock loss in RUN: drop PLL_LOCK -> SYS_RESET=1 within 3 edges, STATE=1, LOSS_COUNT 0->1 (macro defined); relock -> RUN again.
- RESTART from FAULT, and RESTART coincident with the STABLE->RUN transition -> STATE=0 next edge, RETRY_COUNT=0, FAULT=0, PLL_POWERDOWN_N=0 for 4 cycles.
- Async RST asserted mid-RUN between clock edges -> SYS_RESET=1, PLL_POWERDOWN_N=0, READY=0 without waiting for CLK.
